bus_read_demux: RTL and testbench
=================================

Name: bus_read_demux

Overview:
- Read-side counterpart of the 3-to-1 bus output multiplexer on the shared 8-bit parallel bus.
- On request, runs one timed bus read cycle by driving chip-select and read strobe.
- Samples the 8-bit bus and steers the byte into one of three holding registers (Dato1/Dato2/Dato3 equivalents).
- Sits between the controller FSM and the bus pads; all outputs are registered.

Parameters:
- T_SETUP, 2, cycles cs_n low before rd_n falls (legal 1..255)
- T_STROBE, 4, cycles rd_n low; bus sampled at end of last one (legal 1..255)
- T_HOLD, 2, cycles cs_n held low after rd_n rises (legal 1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- inicio  input  1  read request, sampled only in IDLE
- destino  input  2  target register: 0=dato1, 1=dato2, 2=dato3, 3=invalid
- bus_in  input  8  shared bus data from pads
- cs_n  output  1  bus chip-select, active low
- rd_n  output  1  bus read strobe, active low
- ocupado  output  1  high while a read cycle is in progress
- listo  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse with listo when destino was 3
- dato1  output  8  holding register 1
- dato2  output  8  holding register 2
- dato3  output  8  holding register 3

Behaviour:
- Clocking and reset
  - All state and outputs update on the rising edge of clk.
  - reset is synchronous and active-high, with priority over everything else.
  - Reset values: state=IDLE, cs_n=1, rd_n=1, ocupado=0, listo=0, error=0, dato1=dato2=dato3=8'h00, counter=0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit down-counter times each phase.
- IDLE
  - cs_n=1, rd_n=1, ocupado=0.
  - If inicio=1 at edge E0: latch destino into an internal register, load counter=T_SETUP-1, go to SETUP.
- SETUP: cs_n=0, rd_n=1, ocupado=1. When counter=0, load T_STROBE-1 and go to STROBE; otherwise decrement.
- STROBE
  - cs_n=0, rd_n=0, ocupado=1.
  - At the edge where counter=0, capture bus_in into the register selected by the latched destino. Other registers are unchanged.
  - If latched destino=3, discard the data and set an internal error flag.
  - Load T_HOLD-1 and go to HOLD.
- HOLD: cs_n=0, rd_n=1, ocupado=1. When counter=0, go to DONE.
- DONE
  - cs_n=1, rd_n=1, ocupado=0, listo=1 for exactly this cycle.
  - error=1 this cycle if the flag is set; the flag clears on exit.
  - Always return to IDLE.
- Latency
  - The first SETUP cycle follows E0.
  - The updated datoN is visible T_SETUP+T_STROBE cycles after E0.
  - listo is high in the cycle T_SETUP+T_STROBE+T_HOLD edges after E0. With defaults, that is 8 edges.
- Request handling
  - inicio is ignored in SETUP, STROBE, HOLD and DONE, and is not queued.
  - A request held high continuously starts a new read in the first IDLE cycle after DONE, so back-to-back reads are spaced by one IDLE cycle.
  - destino and bus_in changes outside the capture edge have no effect.
- Reset mid-operation: on the next edge, cs_n=1, rd_n=1, ocupado=0, listo=0, all datoN=0, no capture, state=IDLE.
- Glitch-free strobes: cs_n and rd_n are driven from flops only. rd_n is never low while cs_n is high.
- Parameter value 0 is illegal. The implementation need not support it; the bench never uses it.

Test Plan:
- Reset, then 5 idle cycles -> cs_n=1, rd_n=1, ocupado=0, listo=0, dato1..3=00.
- inicio pulse, destino=1, bus_in=8'hA5 throughout -> cs_n low 8 cycles, rd_n low cycles 3-6, dato2=A5 after the 6th edge, listo 1 cycle at edge 8, dato1=dato3=00, error=0.
- Three sequential reads: destino 0/1/2 with bus 8'h12/8'h34/8'h56 -> dato1=12, dato2=34, dato3=56; each read has exactly one listo pulse.
- destino=3, bus=8'hFF -> full strobe sequence, listo=1 with error=1 same cycle, dato1..3 unchanged.
- Bus changes from 8'h00 to 8'h77 one cycle before the capture edge, then to 8'h99 after it -> captured value is 8'h77. A second inicio during STROBE is ignored (one listo only).
- reset asserted in 3rd STROBE cycle of a destino=0 read -> next edge cs_n=1, rd_n=1, ocupado=0, dato1=00, no listo; a new read after release completes normally.

Source files
------------

// File: rtl/bus_read_demux.sv
// bus_read_demux
//   Read-side companion of the 3-to-1 bus output multiplexer. On a request it
//   runs one timed read cycle on the shared 8-bit parallel bus. The cycle has
//   three phases: chip-select setup, read strobe, and chip-select hold. At the
//   end of the strobe phase it samples the bus and steers the byte into one of
//   three holding registers.
//
// Parameters
//   T_SETUP  : cycles cs_n is low before rd_n falls (1..255)
//   T_STROBE : cycles rd_n is low; the bus is sampled on the last one (1..255)
//   T_HOLD   : cycles cs_n stays low after rd_n rises (1..255)
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   inicio  in   read request, honoured only when idle
//   destino in   target register: 0=dato1, 1=dato2, 2=dato3, 3=invalid
//   bus_in  in   byte from the bus pads
//   cs_n    out  bus chip-select, active low (registered)
//   rd_n    out  bus read strobe, active low (registered)
//   ocupado out  high while a read cycle is in progress
//   listo   out  one-cycle completion pulse
//   error   out  one-cycle pulse with listo when the target was invalid
//   dato1..dato3 out  holding registers
module bus_read_demux #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [1:0] destino,
  input  logic [7:0] bus_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       ocupado,
  output logic       listo,
  output logic       error,
  output logic [7:0] dato1,
  output logic [7:0] dato2,
  output logic [7:0] dato3
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Each phase counter is loaded with (length - 1) and the phase ends when it reaches 0.
  localparam logic [7:0] SETUP_LD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(T_HOLD - 1);

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  logic [7:0] cnt_r;
  logic [7:0] next_cnt_s;
  logic [1:0] dest_r;
  logic       err_r;
  logic       capture_s;
  logic       bus_active_s;

  // Next-state, phase counter and capture-edge decode.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (inicio) begin
          next_state_s = ST_SETUP;
          next_cnt_s   = SETUP_LD;
        end else begin
          next_state_s = ST_IDLE;
          next_cnt_s   = 8'd0;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 8'd0) begin
          next_state_s = ST_STROBE;
          next_cnt_s   = STROBE_LD;
        end else begin
          next_cnt_s = cnt_r - 8'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_r == 8'd0) begin
          next_state_s = ST_HOLD;
          next_cnt_s   = HOLD_LD;
          capture_s    = 1'b1;
        end else begin
          next_cnt_s = cnt_r - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          next_state_s = ST_DONE;
          next_cnt_s   = 8'd0;
        end else begin
          next_cnt_s = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 8'd0;
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 8'd0;
      end
    endcase
  end

  // The bus is owned in every phase between the request and completion.
  always_comb begin
    if ((next_state_s == ST_SETUP) || (next_state_s == ST_STROBE) ||
        (next_state_s == ST_HOLD)) begin
      bus_active_s = 1'b1;
    end else begin
      bus_active_s = 1'b0;
    end
  end

  // FSM state, counter, latched target and the invalid-target flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      dest_r  <= 2'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if ((state_r == ST_IDLE) && inicio) begin
        dest_r <= destino;
      end
      // Flag survives through HOLD so it can be reported together with listo.
      if (capture_s && (dest_r == 2'd3)) begin
        err_r <= 1'b1;
      end else if (state_r == ST_DONE) begin
        err_r <= 1'b0;
      end
    end
  end

  // Bus strobes and status are decoded from the next state so that every
  // output comes straight from a flop. rd_n can only be low inside the cs_n
  // window because STROBE is one of the bus-active states.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      error   <= 1'b0;
    end else begin
      cs_n    <= ~bus_active_s;
      rd_n    <= ~(next_state_s == ST_STROBE);
      ocupado <= bus_active_s;
      listo   <= (next_state_s == ST_DONE);
      error   <= (next_state_s == ST_DONE) && err_r;
    end
  end

  // Demultiplex the sampled byte into the selected holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato1 <= 8'h00;
      dato2 <= 8'h00;
      dato3 <= 8'h00;
    end else if (capture_s) begin
      case (dest_r)
        2'd0:    dato1 <= bus_in;
        2'd1:    dato2 <= bus_in;
        2'd2:    dato3 <= bus_in;
        default: ; // invalid target: byte discarded, reported via error
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_demux.sv
module tb_bus_read_demux;

  localparam int TS = 2;
  localparam int TT = 4;
  localparam int TH = 2;
  localparam int L  = TS + TT + TH;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio;
  logic [1:0] destino;
  logic [7:0] bus_in;
  logic       cs_n, rd_n, ocupado, listo, error;
  logic [7:0] dato1, dato2, dato3;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl [3];

  typedef struct {
    logic [1:0] dest;
    logic [7:0] busv;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
  } vec_t;
  vec_t tbl [5];

  bus_read_demux #(.T_SETUP(TS), .T_STROBE(TT), .T_HOLD(TH)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .destino(destino), .bus_in(bus_in),
    .cs_n(cs_n), .rd_n(rd_n), .ocupado(ocupado), .listo(listo), .error(error),
    .dato1(dato1), .dato2(dato2), .dato3(dato3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_datos(input string tag);
    chk({tag, "_dato1"}, dato1, mdl[0]);
    chk({tag, "_dato2"}, dato2, mdl[1]);
    chk({tag, "_dato3"}, dato3, mdl[2]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs_n"}, {7'd0, cs_n}, 8'd1);
    chk({tag, "_rd_n"}, {7'd0, rd_n}, 8'd1);
    chk({tag, "_ocupado"}, {7'd0, ocupado}, 8'd0);
    chk({tag, "_listo"}, {7'd0, listo}, 8'd0);
    chk({tag, "_error"}, {7'd0, error}, 8'd0);
    chk_datos(tag);
  endtask

  // mode 0: fixed bus; 1: random bus/destino each cycle;
  // 2: bus 00 -> 77 (cycle before capture) -> 99, plus a stray inicio in STROBE;
  // 3: inicio held high for the whole read.
  task automatic run_read(input logic [1:0] d, input int mode, input logic [7:0] bv);
    logic [7:0] cap;
    cap = 8'h00;
    @(negedge clk);
    inicio  = 1'b1;
    destino = d;
    bus_in  = (mode == 2) ? 8'h00 : bv;
    @(posedge clk);
    for (int m = 1; m <= L + 1; m++) begin
      @(negedge clk);
      inicio = (mode == 3) || ((mode == 2) && (m == TS + 2));
      if (mode == 1) begin
        destino = 2'($urandom);
        bus_in  = 8'($urandom);
      end
      if (mode == 2) begin
        bus_in = (m < TS + TT) ? 8'h00 : ((m == TS + TT) ? 8'h77 : 8'h99);
      end
      if (m == TS + TT) cap = bus_in;
      if ((m == TS + TT + 1) && (d != 2'd3)) mdl[d] = cap;
      chk("cs_n", {7'd0, cs_n}, {7'd0, ~(m <= L)});
      chk("rd_n", {7'd0, rd_n}, {7'd0, ~((m > TS) && (m <= TS + TT))});
      chk("ocupado", {7'd0, ocupado}, {7'd0, (m <= L)});
      chk("listo", {7'd0, listo}, {7'd0, (m == L + 1)});
      chk("error", {7'd0, error}, {7'd0, ((m == L + 1) && (d == 2'd3))});
      chk_datos("cyc");
    end
    if (mode == 2) begin
      // A stray request seen during STROBE must not start another read.
      inicio = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk_idle("no_requeue");
      end
    end
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; destino = 2'd0; bus_in = 8'h00;
    mdl[0] = 8'h00; mdl[1] = 8'h00; mdl[2] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_idle("rst");
    end

    // Directed table: each read's expected register contents are fixed constants.
    tbl[0] = '{2'd1, 8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[1] = '{2'd0, 8'h12, 8'h12, 8'hA5, 8'h00};
    tbl[2] = '{2'd1, 8'h34, 8'h12, 8'h34, 8'h00};
    tbl[3] = '{2'd2, 8'h56, 8'h12, 8'h34, 8'h56};
    tbl[4] = '{2'd3, 8'hFF, 8'h12, 8'h34, 8'h56};
    for (int i = 0; i < 5; i++) begin
      run_read(tbl[i].dest, 0, tbl[i].busv);
      chk("tbl_dato1", dato1, tbl[i].e1);
      chk("tbl_dato2", dato2, tbl[i].e2);
      chk("tbl_dato3", dato3, tbl[i].e3);
    end

    // Capture-edge timing and stray request.
    run_read(2'd0, 2, 8'h00);
    chk("glitch_capture", dato1, 8'h77);

    // Back-to-back reads with inicio held: second starts after one IDLE cycle.
    run_read(2'd2, 3, 8'h3C);
    run_read(2'd1, 3, 8'hC3);
    run_read(2'd0, 0, 8'h81);

    // Randomized reads against the model.
    for (int i = 0; i < 20; i++) begin
      run_read(2'($urandom_range(0, 3)), 1, 8'h00);
    end

    // Reset during the third STROBE cycle of a destino=0 read.
    @(negedge clk);
    inicio = 1'b1; destino = 2'd0; bus_in = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    repeat (TS + 2) @(negedge clk);
    chk("pre_rst_rd_n", {7'd0, rd_n}, 8'd0);
    reset = 1'b1;
    mdl[0] = 8'h00; mdl[1] = 8'h00; mdl[2] = 8'h00;
    @(negedge clk);
    chk_idle("midrst");
    reset = 1'b0;
    repeat (L + 2) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    run_read(2'd0, 0, 8'h5A);
    chk("after_rst_read", dato1, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
